// File: rtl/shift_sub_div_pkg.sv
// rtl/shift_sub_div_pkg.sv - shared FSM definitions for the shift-subtract divider
// Holds the 2-bit state width and the state encodings IDLE=0, LOAD=1, CALC=2, DONE=3,
// the same encoding the shift-add multiplier FSM uses.
package shift_sub_div_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/shift_sub_div_sub.sv
// rtl/shift_sub_div_sub.sv - W-bit unsigned subtractor with borrow for the divider datapath
// Ports:
//   a, b    in   W    minuend, subtrahend
//   diff    out  W-1  low W-1 bits of a - b
//   borrow  out  1    top bit of a - b (1 when a < b)
module sub_n #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-2:0] diff,
    output logic         borrow
);

    logic [W-1:0] full;

    assign full   = a - b;
    assign diff   = full[W-2:0];
    assign borrow = full[W-1];

endmodule

// File: rtl/shift_sub_div.sv
// rtl/shift_sub_div.sv - sequential restoring (shift-subtract) unsigned divider, one quotient bit per clock
// Optional feature macro: SHIFT_SUB_DIV_DZ_EN (adds the dz divide-by-zero flag and zeroes the result).
// Ports:
//   clk        in   1  system clock, posedge
//   rst        in   1  asynchronous active-high reset
//   start      in   1  start button level; operation starts on its falling edge
//   src1       in   N  dividend, sampled in LOAD
//   src2       in   N  divisor, sampled in LOAD
//   quotient   out  N  src1 / src2 while in DONE, else 0
//   remainder  out  N  src1 % src2 while in DONE, else 0
//   valid      out  1  one-cycle pulse on the first DONE cycle
//   busy       out  1  high in LOAD and CALC
//   dz         out  1  divide-by-zero flag (SHIFT_SUB_DIV_DZ_EN only)
module shift_sub_div
    import shift_sub_div_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] src1,
    input  logic [N-1:0] src2,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         valid,
`ifdef SHIFT_SUB_DIV_DZ_EN
    output logic         dz,
`endif
    output logic         busy
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state, next_state;
    logic          start_d;
    logic          start_edge;
    logic [N-1:0]  d_reg;
    logic [N-1:0]  q_reg;
    // The partial remainder is conceptually N+1 bits, but its top bit is always 0
    // after a successful subtract and is shifted out otherwise, so only N bits are kept.
    logic [N-1:0]  r_reg;
    logic [CW-1:0] cnt;
    logic          vflag;
    logic          vflag_d;
    logic [N:0]    shifted;
    logic [N-1:0]  t_low;
    logic          borrow;
    logic          show;

    // Release of the button, not the press, launches the operation.
    assign start_edge = start_d & ~start;

    assign shifted = {r_reg, q_reg[N-1]};

    sub_n #(.W(N + 1)) u_sub (
        .a      (shifted),
        .b      ({1'b0, d_reg}),
        .diff   (t_low),
        .borrow (borrow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_edge) next_state = LOAD;
            LOAD:    next_state = CALC;
            CALC:    if (cnt == LAST) next_state = DONE;
            DONE:    if (start_edge) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_d <= 1'b0;
            d_reg   <= '0;
            q_reg   <= '0;
            r_reg   <= '0;
            cnt     <= '0;
            vflag   <= 1'b0;
            vflag_d <= 1'b0;
        end else begin
            start_d <= start;
            vflag_d <= vflag;
            case (state)
                LOAD: begin
                    d_reg <= src2;
                    q_reg <= src1;
                    r_reg <= '0;
                    cnt   <= '0;
                    vflag <= 1'b0;
                end
                CALC: begin
                    if (!borrow) begin
                        r_reg <= t_low;
                        q_reg <= {q_reg[N-2:0], 1'b1};
                    end else begin
                        r_reg <= shifted[N-1:0];
                        q_reg <= {q_reg[N-2:0], 1'b0};
                    end
                    cnt <= cnt + CW'(1);
                    // Raised on the way into DONE so the pulse lands on the first DONE cycle.
                    if (cnt == LAST) begin
                        vflag <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SHIFT_SUB_DIV_DZ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dz <= 1'b0;
        end else if (state == LOAD) begin
            dz <= (src2 == '0);
        end else if (state == IDLE) begin
            dz <= 1'b0;
        end
    end

    assign show = (state == DONE) && !dz;
`else
    assign show = (state == DONE);
`endif

    assign quotient  = show ? q_reg : '0;
    assign remainder = show ? r_reg : '0;
    assign valid     = vflag & ~vflag_d;
    assign busy      = (state == LOAD) || (state == CALC);

endmodule

// File: tb/tb_shift_sub_div.sv
// tb/tb_shift_sub_div.sv - self-checking bench for shift_sub_div (N=4) against an arithmetic reference
module tb_shift_sub_div;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] src1 = '0;
    logic [N-1:0] src2 = '0;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         valid;
    logic         busy;
`ifdef SHIFT_SUB_DIV_DZ_EN
    logic         dz;
`endif

    int tests = 0;
    int fails = 0;

    shift_sub_div #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src1      (src1),
        .src2      (src2),
        .quotient  (quotient),
        .remainder (remainder),
        .valid     (valid),
`ifdef SHIFT_SUB_DIV_DZ_EN
        .dz        (dz),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_q(input int a, input int b);
`ifdef SHIFT_SUB_DIV_DZ_EN
        if (b == 0) return 0;
`else
        if (b == 0) return (1 << N) - 1;
`endif
        return a / b;
    endfunction

    function automatic int ref_r(input int a, input int b);
`ifdef SHIFT_SUB_DIV_DZ_EN
        if (b == 0) return 0;
`else
        if (b == 0) return a;
`endif
        return a % b;
    endfunction

    // mode 0: plain operation; mode 1: start re-released and operands scrambled during CALC
    task automatic do_op(input int a, input int b, input int mode);
        int lat;
        int eq;
        int er;
        lat = 0;
        eq  = ref_q(a, b);
        er  = ref_r(a, b);
        @(negedge clk);
        src1  = N'(a);
        src2  = N'(b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("load_busy", 32'(busy), 1);
                check("load_q_zero", 32'(quotient), 0);
            end
            if (i == 3) begin
                check("calc_q_zero", 32'(quotient), 0);
                check("calc_r_zero", 32'(remainder), 0);
                check("calc_busy", 32'(busy), 1);
            end
            if (mode == 1 && i == 2) begin
                start = 1'b1;
                src1  = N'($urandom);
                src2  = N'($urandom);
            end
            if (mode == 1 && i == 3) begin
                start = 1'b0;
            end
            if (valid) begin
                lat = i;
                break;
            end
        end
        check("latency", 32'(lat), N + 2);
        check("quotient", 32'(quotient), 32'(eq));
        check("remainder", 32'(remainder), 32'(er));
        check("done_busy", 32'(busy), 0);
`ifdef SHIFT_SUB_DIV_DZ_EN
        check("dz", 32'(dz), (b == 0) ? 1 : 0);
`endif
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("valid_single", 32'(valid), 0);
            check("done_hold_q", 32'(quotient), 32'(eq));
        end
    endtask

    initial begin
        int seen;
        int a;
        int b;

        #1;
        check("rst_quotient", 32'(quotient), 0);
        check("rst_remainder", 32'(remainder), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
`ifdef SHIFT_SUB_DIV_DZ_EN
        check("rst_dz", 32'(dz), 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_op(13, 4, 0);
        do_op(15, 1, 0);
        do_op(3, 7, 0);
        do_op(0, 5, 0);
        do_op(15, 15, 0);
        do_op(9, 0, 0);
        do_op(13, 4, 1);

        // Reset asserted in the second CALC cycle aborts without a valid pulse.
        @(negedge clk);
        src1  = 4'd13;
        src2  = 4'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_quotient", 32'(quotient), 0);
        check("abort_remainder", 32'(remainder), 0);
        check("abort_valid", 32'(valid), 0);
        check("abort_busy", 32'(busy), 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid) seen++;
        end
        check("abort_no_valid", 32'(seen), 0);

        do_op(13, 4, 0);
        do_op(7, 2, 0);

        for (int x = 0; x < (1 << N); x++) begin
            for (int y = 0; y < (1 << N); y++) begin
                do_op(x, y, 0);
            end
        end

        for (int k = 0; k < 30; k++) begin
            a = int'($urandom_range((1 << N) - 1, 0));
            b = int'($urandom_range((1 << N) - 1, 0));
            do_op(a, b, int'($urandom_range(1, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
